lif_step_scheduler: RTL and testbench

- Upstream controller for the LIF neuron update unit. Each timestep it walks every neuron index, fetches that neuron's bias, encoder term and stored state, and fires a one-cycle `start_lif`.
- It then waits for `lif_spike_valid`, writes the returned voltage and refractory count back to its internal state memory, and emits a spike event for each firing neuron.
- Data words are IEEE-754 single precision, 32 bits.

---
 rtl/lif_step_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_lif_step_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_step_scheduler.sv
// Timestep sequencer for the LIF neuron update unit: fetches operands,
// issues each neuron update, writes results back and emits spike events.
module lif_step_scheduler #(
  parameter int NUM_NEURONS = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int TIMEOUT     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step_start,
  output logic                  busy,
  output logic                  step_done,
  output logic [15:0]           timestep,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] param_addr,
  input  logic [31:0]           param_bias,
  input  logic [31:0]           param_enc,
  output logic                  start_lif,
  output logic [31:0]           lif_bias,
  output logic [31:0]           lif_encoders,
  output logic [31:0]           lif_voltage_old,
  output logic [1:0]            lif_refractory_old,
  input  logic                  lif_spike_valid,
  input  logic [31:0]           lif_voltage_new,
  input  logic [1:0]            lif_refractory_new,
  input  logic                  lif_spike,
  output logic                  spike_out_valid,
  output logic [ADDR_WIDTH-1:0] spike_out_id,
  input  logic                  spike_out_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_NEURONS - 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_FETCH, S_LOAD, S_ISSUE,
    S_WAIT, S_WRITE, S_EMIT, S_NEXT
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [31:0]           bias_q, bias_d;
  logic [31:0]           enc_q, enc_d;
  logic [31:0]           vold_q, vold_d;
  logic [1:0]            rold_q, rold_d;
  logic [33:0]           rd_q, rd_d;
  logic [31:0]           vnew_q, vnew_d;
  logic [1:0]            rnew_q, rnew_d;
  logic                  spk_q, spk_d;
  logic [15:0]           ts_q, ts_d;
  logic                  err_q, err_d;

  // Per-neuron state word: {voltage, refractory}
  logic [33:0] mem_q [NUM_NEURONS];
  logic        mem_we;
  logic [33:0] mem_wdata;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    bias_d    = bias_q;
    enc_d     = enc_q;
    vold_d    = vold_q;
    rold_d    = rold_q;
    rd_d      = rd_q;
    vnew_d    = vnew_q;
    rnew_d    = rnew_q;
    spk_d     = spk_q;
    ts_d      = ts_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_wdata = '0;
    unique case (state_q)
      S_INIT: begin
        mem_we = 1'b1;
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (step_start) begin
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        rd_d    = mem_q[idx_q];
        state_d = S_LOAD;
      end
      S_LOAD: begin
        bias_d  = param_bias;
        enc_d   = param_enc;
        vold_d  = rd_q[33:2];
        rold_d  = rd_q[1:0];
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lif_spike_valid) begin
          vnew_d  = lif_voltage_new;
          rnew_d  = lif_refractory_new;
          spk_d   = lif_spike;
          state_d = S_WRITE;
        end else if (cnt_q == TMAX) begin
          // Abandon this neuron: old state stays, no spike
          err_d   = 1'b1;
          state_d = S_NEXT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRITE: begin
        mem_we    = 1'b1;
        mem_wdata = {vnew_q, rnew_q};
        state_d   = spk_q ? S_EMIT : S_NEXT;
      end
      S_EMIT: begin
        if (spike_out_ready) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (idx_q == LAST) begin
          idx_d   = '0;
          ts_d    = ts_q + 16'd1;
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      idx_q   <= '0;
      cnt_q   <= '0;
      bias_q  <= '0;
      enc_q   <= '0;
      vold_q  <= '0;
      rold_q  <= '0;
      rd_q    <= '0;
      vnew_q  <= '0;
      rnew_q  <= '0;
      spk_q   <= 1'b0;
      ts_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      bias_q  <= bias_d;
      enc_q   <= enc_d;
      vold_q  <= vold_d;
      rold_q  <= rold_d;
      rd_q    <= rd_d;
      vnew_q  <= vnew_d;
      rnew_q  <= rnew_d;
      spk_q   <= spk_d;
      ts_q    <= ts_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[idx_q] <= mem_wdata;
  end

  assign busy               = (state_q != S_IDLE);
  assign step_done          = (state_q == S_NEXT) && (idx_q == LAST);
  assign timestep           = ts_q;
  assign error              = err_q;
  assign param_addr         = (state_q == S_FETCH) ? idx_q : '0;
  assign start_lif          = (state_q == S_ISSUE);
  assign lif_bias           = bias_q;
  assign lif_encoders       = enc_q;
  assign lif_voltage_old    = vold_q;
  assign lif_refractory_old = rold_q;
  assign spike_out_valid    = (state_q == S_EMIT);
  assign spike_out_id       = (state_q == S_EMIT) ? idx_q : '0;

endmodule

// File: tb/tb_lif_step_scheduler.sv
// Scoreboard bench for lif_step_scheduler with a stub LIF unit,
// a registered parameter memory and a neuron-state reference model.
module tb_lif_step_scheduler;

  localparam int N  = 16;
  localparam int AW = 4;
  localparam int TO = 32;

  logic          clk = 0;
  logic          rst = 1;
  logic          step_start = 0;
  logic          busy, step_done, error, start_lif;
  logic [15:0]   timestep;
  logic [AW-1:0] param_addr, spike_out_id;
  logic [31:0]   param_bias = 0, param_enc = 0;
  logic [31:0]   lif_bias, lif_encoders, lif_voltage_old;
  logic [1:0]    lif_refractory_old;
  logic          lif_spike_valid = 0;
  logic [31:0]   lif_voltage_new = 0;
  logic [1:0]    lif_refractory_new = 0;
  logic          lif_spike = 0;
  logic          spike_out_valid;
  logic          spike_out_ready = 0;

  lif_step_scheduler #(.NUM_NEURONS(N), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .step_start(step_start), .busy(busy),
    .step_done(step_done), .timestep(timestep), .error(error),
    .param_addr(param_addr), .param_bias(param_bias), .param_enc(param_enc),
    .start_lif(start_lif), .lif_bias(lif_bias), .lif_encoders(lif_encoders),
    .lif_voltage_old(lif_voltage_old), .lif_refractory_old(lif_refractory_old),
    .lif_spike_valid(lif_spike_valid), .lif_voltage_new(lif_voltage_new),
    .lif_refractory_new(lif_refractory_new), .lif_spike(lif_spike),
    .spike_out_valid(spike_out_valid), .spike_out_id(spike_out_id),
    .spike_out_ready(spike_out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [31:0] b, e, v;
    logic [1:0]  r;
  } op_t;

  op_t  exp_op[$];
  int   exp_spk[$];
  int   tests = 0, fails = 0;

  logic [31:0] bias_mem [N];
  logic [31:0] enc_mem  [N];
  logic [31:0] model_v  [N];
  logic [1:0]  model_r  [N];
  logic [15:0] ts_model;
  bit          err_model;

  logic [31:0] resp_v    [N];
  logic [1:0]  resp_r    [N];
  bit          resp_s    [N];
  bit          resp_none [N];
  int          resp_lat  [N];

  int ready_mode = 0;
  int starts = 0, done_cnt = 0, cyc = 0;
  int issue_cyc [N];
  int err_cyc = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    param_bias <= bias_mem[param_addr];
    param_enc  <= enc_mem[param_addr];
  end

  // Stub LIF unit
  int          nc = 0, cur = 0, rem = 0;
  bit          pend = 0;
  logic [97:0] iss_ops;
  always @(negedge clk) begin
    lif_spike_valid    = 0;
    lif_voltage_new    = $urandom;
    lif_refractory_new = 2'($urandom_range(0, 3));
    lif_spike          = 1'($urandom_range(0, 1));
    if (rst) begin
      pend = 0;
      nc   = 0;
    end else begin
      if (step_done) nc = 0;
      if (pend) begin
        rem--;
        if (rem == 0) begin
          pend = 0;
          chk("op_stable", {lif_bias, lif_encoders, lif_voltage_old,
                            lif_refractory_old}, iss_ops);
          lif_spike_valid    = 1;
          lif_voltage_new    = resp_v[cur];
          lif_refractory_new = resp_r[cur];
          lif_spike          = resp_s[cur];
        end
      end
      if (start_lif && nc < N) begin
        cur = nc;
        nc++;
        iss_ops = {lif_bias, lif_encoders, lif_voltage_old,
                   lif_refractory_old};
        if (!resp_none[cur]) begin
          pend = 1;
          rem  = resp_lat[cur];
        end
      end
    end
  end

  // Monitor: drives ready, pops scoreboard queues
  bit            pv = 0, pr = 0, perr = 0;
  logic [AW-1:0] pid = 0;
  int            hold = 0, stall = 0;
  always @(negedge clk) begin
    op_t o;
    if (rst) begin
      pv = 0; pr = 0; perr = 0; hold = 0; stall = 0;
      spike_out_ready = 0;
    end else begin
      case (ready_mode)
        0: spike_out_ready = 1;
        1: begin
          if (!spike_out_valid) begin
            spike_out_ready = 0; hold = 0;
          end else if (hold < 10) begin
            spike_out_ready = 0; hold++;
          end else begin
            spike_out_ready = 1;
          end
        end
        default: spike_out_ready = 1'($urandom_range(0, 1));
      endcase
      if (error && !perr) err_cyc = cyc;
      perr = error;
      if (step_done) done_cnt++;
      if (start_lif) begin
        starts++;
        if (exp_op.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_start: got start_lif required none");
        end else begin
          o = exp_op.pop_front();
          issue_cyc[o.n] = cyc;
          chk($sformatf("bias[%0d]", o.n), lif_bias, o.b);
          chk($sformatf("enc[%0d]", o.n), lif_encoders, o.e);
          chk($sformatf("vold[%0d]", o.n), lif_voltage_old, o.v);
          chk($sformatf("rold[%0d]", o.n), lif_refractory_old, o.r);
          chk($sformatf("emit_order[%0d]", o.n),
              (exp_spk.size() == 0) || (exp_spk[0] >= o.n), 1);
        end
      end
      if (pv && !pr) begin
        chk("spk_hold_valid", spike_out_valid, 1);
        chk("spk_hold_id", spike_out_id, pid);
      end
      if (spike_out_valid && !spike_out_ready) stall++;
      if (spike_out_valid && spike_out_ready) begin
        if (exp_spk.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_spike: got id %0d required none",
                   spike_out_id);
        end else begin
          chk("spike_id", spike_out_id, exp_spk.pop_front());
        end
        if (ready_mode == 1) chk("spk_stall_len", stall, 10);
        stall = 0;
      end
      pv  = spike_out_valid;
      pr  = spike_out_ready;
      pid = spike_out_id;
    end
  end

  task automatic rand_params();
    for (int i = 0; i < N; i++) begin
      bias_mem[i] = $urandom;
      enc_mem[i]  = $urandom;
    end
  endtask

  task automatic set_resp_const(input logic [31:0] v, input logic [1:0] r);
    for (int i = 0; i < N; i++) begin
      resp_v[i] = v; resp_r[i] = r; resp_s[i] = 0;
      resp_none[i] = 0; resp_lat[i] = 4;
    end
  endtask

  task automatic set_resp_rand();
    for (int i = 0; i < N; i++) begin
      resp_v[i]    = $urandom;
      resp_r[i]    = 2'($urandom_range(0, 3));
      resp_s[i]    = ($urandom_range(0, 3) == 0);
      resp_none[i] = 0;
      resp_lat[i]  = $urandom_range(1, 6);
    end
  endtask

  task automatic push_expect();
    op_t o;
    for (int i = 0; i < N; i++) begin
      o.n = i; o.b = bias_mem[i]; o.e = enc_mem[i];
      o.v = model_v[i]; o.r = model_r[i];
      exp_op.push_back(o);
      if (resp_none[i]) begin
        err_model = 1;
      end else begin
        model_v[i] = resp_v[i];
        model_r[i] = resp_r[i];
        if (resp_s[i]) exp_spk.push_back(i);
      end
    end
    ts_model = ts_model + 16'd1;
  endtask

  task automatic go_step();
    int d0, s0;
    bit ok;
    d0 = done_cnt; s0 = starts; ok = 0;
    @(negedge clk); step_start = 1;
    @(negedge clk); step_start = 0;
    for (int i = 0; i < 4000; i++) begin
      if (done_cnt != d0) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("step_done_seen", ok, 1);
    @(negedge clk);
    chk("idle_after_step", busy, 0);
    chk("timestep", timestep, ts_model);
    chk("error", error, err_model);
    chk("starts_per_step", starts - s0, N);
    chk("done_pulses", done_cnt - d0, 1);
    chk("ops_left", exp_op.size(), 0);
    chk("spikes_left", exp_spk.size(), 0);
  endtask

  task automatic do_reset();
    int k, s0;
    @(negedge clk); rst = 1; step_start = 0;
    exp_op.delete(); exp_spk.delete();
    for (int i = 0; i < N; i++) begin model_v[i] = 0; model_r[i] = 0; end
    ts_model = 0; err_model = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_outs", {step_done, timestep, error, param_addr, start_lif,
                     lif_bias, lif_encoders, lif_voltage_old,
                     lif_refractory_old, spike_out_valid, spike_out_id}, 0);
    rst = 0; s0 = starts; k = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 3) step_start = 1;
      if (i == 4) step_start = 0;
      if (!busy) begin k = i; break; end
    end
    chk("init_cycles", k, N);
    repeat (5) @(negedge clk);
    chk("init_start_ignored", starts - s0, 0);
    chk("init_idle", busy, 0);
    chk("init_timestep", timestep, 0);
    chk("init_error", error, 0);
  endtask

  initial begin
    int s0;
    bit ok;
    rand_params();
    set_resp_const(32'h0, 2'd0);
    repeat (3) @(negedge clk);
    do_reset();

    // Constant LIF response, then a random step reading it back
    ready_mode = 0;
    set_resp_const(32'h3F000000, 2'd0);
    push_expect(); go_step();
    rand_params(); set_resp_rand(); ready_mode = 2;
    push_expect(); go_step();

    // Only neuron 5 fires, ready high
    ready_mode = 0;
    set_resp_const(32'h3F000000, 2'd0);
    resp_s[5] = 1; resp_r[5] = 2;
    push_expect(); go_step();

    // Same, with 10 cycles of backpressure
    ready_mode = 1;
    push_expect(); go_step();

    // Neuron 3 never answers
    ready_mode = 2;
    rand_params(); set_resp_rand(); resp_none[3] = 1;
    push_expect(); go_step();
    chk("timeout_latency", err_cyc - issue_cyc[3], TO + 1);
    rand_params(); set_resp_rand();
    push_expect(); go_step();

    // Reset while waiting on neuron 7
    set_resp_const(32'h40400000, 2'd1); resp_lat[7] = 20;
    push_expect();
    s0 = starts; ok = 0;
    @(negedge clk); step_start = 1;
    @(negedge clk); step_start = 0;
    for (int i = 0; i < 2000; i++) begin
      if (starts - s0 >= 8) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("reached_neuron7", ok, 1);
    do_reset();
    rand_params(); set_resp_rand();
    push_expect(); go_step();

    for (int t = 0; t < 3; t++) begin
      rand_params(); set_resp_rand();
      push_expect(); go_step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
